// File: rtl/rm_lane_allocator.sv
// Runtime-monitor lane allocator and event encoder; optional lane timeout under RM_LANE_TIMEOUT_EN.
// Latency: grant is combinational, events_o is registered one cycle after the probe.
// Backpressure: none; denied requests and lost probes add to the saturating drop counter.
package ariane_pkg;
    localparam int unsigned RM_LANE_W  = 3;
    localparam int unsigned RM_ITYPE_W = 1;

    typedef struct packed {
        logic                  two_lane;
        logic [RM_LANE_W-1:0]  lane0;
        logic [RM_LANE_W-1:0]  lane1;
        logic [RM_ITYPE_W-1:0] itype;
        logic                  probe_val;
        logic                  reset_lane;
    } lane_ctrl;
endpackage

module rm_lane_allocator #(
    parameter int NUM_LANES         = 5,
    parameter int NUM_EVENTS        = 10,
    parameter int NUM_MONITORED_INS = 2,
    parameter int LANE_TIMEOUT      = 64
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    alloc_req_i,
    input  logic [$clog2(NUM_MONITORED_INS)-1:0]    alloc_itype_i,
    output logic                                    alloc_gnt_o,
    output logic [$clog2(NUM_LANES)-1:0]            alloc_lane_o,
    input  logic                                    release_valid_i,
    input  logic [$clog2(NUM_LANES)-1:0]            release_lane_i,
    input  logic [NUM_EVENTS-1:0]                   probe_i,
    input  logic [NUM_EVENTS-1:0]                   cfg_two_lane_i,
    output ariane_pkg::lane_ctrl [NUM_EVENTS-1:0]   events_o,
    output logic [NUM_LANES-1:0]                    busy_o,
    output logic [15:0]                             drop_cnt_o
);
    localparam int LW  = $clog2(NUM_LANES);
    localparam int IW  = $clog2(NUM_MONITORED_INS);
    localparam int PLW = ariane_pkg::RM_LANE_W;
    localparam int PIW = ariane_pkg::RM_ITYPE_W;

    logic [NUM_LANES-1:0]  busy_q, busy_d;
    logic [IW-1:0]         itype_q [NUM_LANES];
    logic [LW-1:0]         cur_q, prev_q, alloc_lane;
    logic                  cur_v_q, prev_v_q;
    ariane_pkg::lane_ctrl [NUM_EVENTS-1:0] events_q, events_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d, drops;
    logic [16:0]           drop_sum;
    logic                  exp_rel, rel_v;
    logic [LW-1:0]         rel_lane;

    always_comb begin
        alloc_lane = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (!busy_q[l]) alloc_lane = LW'(l);
        end
    end

    assign alloc_gnt_o  = alloc_req_i & ~&busy_q;
    assign alloc_lane_o = alloc_lane;
    assign exp_rel      = release_valid_i && (32'(release_lane_i) < NUM_LANES) && busy_q[release_lane_i];

`ifdef RM_LANE_TIMEOUT_EN
    localparam int CW = $clog2(LANE_TIMEOUT);

    logic [CW-1:0]         to_cnt_q [NUM_LANES];
    logic [NUM_LANES-1:0]  expired;
    logic                  pend_v_q, pend_v_d, auto_v;
    logic [LW-1:0]         pend_lane_q, pend_lane_d, auto_lane;

    // A lane being explicitly released this edge is not also a timeout candidate.
    always_comb begin
        expired   = '0;
        auto_lane = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            expired[l] = busy_q[l] && (to_cnt_q[l] == CW'(LANE_TIMEOUT - 1))
                         && !(exp_rel && (release_lane_i == LW'(l)));
        end
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (expired[l]) auto_lane = LW'(l);
        end
        auto_v = |expired;
        if (pend_v_q) begin
            auto_lane = pend_lane_q;
            auto_v    = !(exp_rel && (release_lane_i == pend_lane_q));
        end
        rel_v       = exp_rel | auto_v;
        rel_lane    = exp_rel ? release_lane_i : auto_lane;
        pend_v_d    = exp_rel & auto_v;
        pend_lane_d = auto_lane;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_v_q    <= 1'b0;
            pend_lane_q <= '0;
            for (int l = 0; l < NUM_LANES; l++) to_cnt_q[l] <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_lane_q <= pend_lane_d;
            for (int l = 0; l < NUM_LANES; l++) begin
                if ((alloc_gnt_o && alloc_lane == LW'(l)) || (rel_v && rel_lane == LW'(l)))
                    to_cnt_q[l] <= '0;
                else if (busy_q[l] && to_cnt_q[l] != CW'(LANE_TIMEOUT - 1))
                    to_cnt_q[l] <= to_cnt_q[l] + 1'b1;
            end
        end
    end
`else
    assign rel_v    = exp_rel;
    assign rel_lane = release_lane_i;
`endif

    always_comb begin
        busy_d = busy_q;
        if (rel_v)       busy_d[rel_lane]   = 1'b0;
        if (alloc_gnt_o) busy_d[alloc_lane] = 1'b1;
    end

    always_comb begin
        events_d = '0;
        drops    = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (i == NUM_EVENTS - 1 && rel_v) begin
                events_d[i].lane0      = PLW'(rel_lane);
                events_d[i].reset_lane = 1'b1;
                if (probe_i[i]) drops = drops + 16'd1;
            end else begin
                events_d[i].two_lane  = cfg_two_lane_i[i] & prev_v_q;
                events_d[i].lane0     = PLW'(cur_q);
                events_d[i].lane1     = PLW'(prev_q);
                events_d[i].itype     = PIW'(events_d[i].two_lane ? itype_q[prev_q] : itype_q[cur_q]);
                events_d[i].probe_val = probe_i[i] & (events_d[i].two_lane ? prev_v_q : cur_v_q);
                if (probe_i[i] && !events_d[i].probe_val) drops = drops + 16'd1;
            end
        end
        if (alloc_req_i && !alloc_gnt_o) drops = drops + 16'd1;
        drop_sum   = {1'b0, drop_cnt_q} + {1'b0, drops};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // A release landing on the current lane must not resurrect its valid bit when it shifts to prev.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            cur_q      <= '0;
            prev_q     <= '0;
            cur_v_q    <= 1'b0;
            prev_v_q   <= 1'b0;
            events_q   <= '0;
            drop_cnt_q <= '0;
            for (int l = 0; l < NUM_LANES; l++) itype_q[l] <= '0;
        end else begin
            busy_q     <= busy_d;
            events_q   <= events_d;
            drop_cnt_q <= drop_cnt_d;
            if (alloc_gnt_o) begin
                itype_q[alloc_lane] <= alloc_itype_i;
                prev_q   <= cur_q;
                prev_v_q <= cur_v_q && !(rel_v && rel_lane == cur_q);
                cur_q    <= alloc_lane;
                cur_v_q  <= 1'b1;
            end else begin
                if (rel_v && rel_lane == cur_q)  cur_v_q  <= 1'b0;
                if (rel_v && rel_lane == prev_q) prev_v_q <= 1'b0;
            end
        end
    end

    assign events_o   = events_q;
    assign busy_o     = busy_q;
    assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_rm_lane_allocator.sv
// Directed bench for rm_lane_allocator with hand-computed expectations.
module tb_rm_lane_allocator;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alloc_req_i = 1'b0;
    logic [0:0]  alloc_itype_i = '0;
    logic        alloc_gnt_o;
    logic [2:0]  alloc_lane_o;
    logic        release_valid_i = 1'b0;
    logic [2:0]  release_lane_i = '0;
    logic [9:0]  probe_i = '0;
    logic [9:0]  cfg_two_lane_i = '0;
    ariane_pkg::lane_ctrl [9:0] events_o;
    logic [4:0]  busy_o;
    logic [15:0] drop_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    rm_lane_allocator #(
        .NUM_LANES(5), .NUM_EVENTS(10), .NUM_MONITORED_INS(2), .LANE_TIMEOUT(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_req_i(alloc_req_i), .alloc_itype_i(alloc_itype_i),
        .alloc_gnt_o(alloc_gnt_o), .alloc_lane_o(alloc_lane_o),
        .release_valid_i(release_valid_i), .release_lane_i(release_lane_i),
        .probe_i(probe_i), .cfg_two_lane_i(cfg_two_lane_i),
        .events_o(events_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic two, input logic [2:0] l0, input logic [2:0] l1,
                                       input logic it, input logic pv, input logic rl);
        ariane_pkg::lane_ctrl e;
        e.two_lane = two; e.lane0 = l0; e.lane1 = l1; e.itype = it; e.probe_val = pv; e.reset_lane = rl;
        return 32'(e);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req_i = 1'b0; alloc_itype_i = '0; release_valid_i = 1'b0;
        release_lane_i = '0; probe_i = '0; cfg_two_lane_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic alloc(input logic it, input logic [2:0] exp_lane, input string tag);
        alloc_req_i = 1'b1; alloc_itype_i = it;
        #1;
        check({tag, "_gnt"}, 32'(alloc_gnt_o), 32'd1);
        check({tag, "_lane"}, 32'(alloc_lane_o), 32'(exp_lane));
        tick();
        alloc_req_i = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_events", 32'(events_o == '0), 32'd1);
        rst_ni = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) alloc(1'(k % 2), 3'(k), "fill");
        check("fill_busy", 32'(busy_o), 32'h1F);
        alloc_req_i = 1'b1;
        #1;
        check("full_gnt", 32'(alloc_gnt_o), 32'd0);
        tick();
        alloc_req_i = 1'b0;
        check("full_drop", 32'(drop_cnt_o), 32'd1);

        do_reset();
        check("rst2_drop", 32'(drop_cnt_o), 32'd0);
        alloc(1'b1, 3'd0, "a0");
        alloc(1'b0, 3'd1, "a1");
        probe_i = 10'h003; cfg_two_lane_i = 10'h002;
        tick();
        idle_inputs();
        check("enc_slot0", 32'(events_o[0]), mk(1'b0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0));
        check("enc_slot1", 32'(events_o[1]), mk(1'b1, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0));
        check("enc_slot2", 32'(events_o[2]), mk(1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0));
        check("enc_drop", 32'(drop_cnt_o), 32'd0);

        release_valid_i = 1'b1; release_lane_i = 3'd1; probe_i = 10'h200;
        tick();
        idle_inputs();
        check("rel_pulse", 32'(events_o[9]), mk(1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1));
        check("rel_drop", 32'(drop_cnt_o), 32'd1);
        check("rel_busy", 32'(busy_o), 32'h01);
        probe_i = 10'h005; cfg_two_lane_i = 10'h004;
        tick();
        idle_inputs();
        check("curv_slot0", 32'(events_o[0]), mk(1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0));
        check("curv_slot2", 32'(events_o[2]), mk(1'b1, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0));
        check("curv_slot9", 32'(events_o[9]), mk(1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0));
        check("curv_drop", 32'(drop_cnt_o), 32'd2);

        do_reset();
        for (int k = 0; k < 5; k++) alloc(1'b0, 3'(k), "refill");
        alloc_req_i = 1'b1; release_valid_i = 1'b1; release_lane_i = 3'd2;
        #1;
        check("nobypass_gnt", 32'(alloc_gnt_o), 32'd0);
        tick();
        idle_inputs();
        check("nobypass_busy", 32'(busy_o), 32'h1B);
        check("nobypass_drop", 32'(drop_cnt_o), 32'd1);
        check("nobypass_pulse", 32'(events_o[9]), mk(1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1));
        alloc(1'b1, 3'd2, "regrant");
        check("regrant_busy", 32'(busy_o), 32'h1F);

        // async reset lands mid-cycle while a release is being requested
        release_valid_i = 1'b1; release_lane_i = 3'd0; probe_i = 10'h3FF;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_events", 32'(events_o == '0), 32'd1);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_drop", 32'(drop_cnt_o), 32'd0);
        idle_inputs();
        #2;
        rst_ni = 1'b1;
        tick();
        check("arst_nopulse", 32'(events_o == '0), 32'd1);
        check("arst_drop2", 32'(drop_cnt_o), 32'd0);

`ifdef RM_LANE_TIMEOUT_EN
        do_reset();
        alloc(1'b0, 3'd0, "to_a");
        tick(); tick(); tick();
        check("to_busy_e3", 32'(busy_o), 32'h01);
        tick();
        check("to_busy_e4", 32'(busy_o), 32'h00);
        check("to_pulse", 32'(events_o[9]), mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        alloc(1'b0, 3'd0, "to_b0");
        alloc(1'b0, 3'd1, "to_b1");
        alloc(1'b0, 3'd2, "to_b2");
        tick();
        release_valid_i = 1'b1; release_lane_i = 3'd2;
        tick();
        idle_inputs();
        check("to_coll_busy", 32'(busy_o), 32'h03);
        check("to_coll_pulse", 32'(events_o[9]), mk(1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1));
        tick();
        check("to_pend_busy", 32'(busy_o), 32'h02);
        check("to_pend_pulse", 32'(events_o[9]), mk(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1));
        tick();
        check("to_next_busy", 32'(busy_o), 32'h00);
        check("to_next_pulse", 32'(events_o[9]), mk(1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
